intr_ctrl: RTL and testbench

//   Interrupt controller between the I/O block's 8 interrupt lines and the CPU.
//   - Detects rising edges on the lines and latches them as pending.
//   - Masks pending lines with software enables and picks the lowest-index

---
 rtl/intr_ctrl.sv | 137 +++++++++++++
 tb/tb_intr_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/intr_ctrl.sv
// Interrupt controller: rising-edge latch on 8 lines, enable masking,
// lowest-index priority and a req/ack/done handshake with the CPU.
module intr_ctrl #(
  parameter logic [4:0] BASE_ADDR = 5'd4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] irq_in,
  input  logic [4:0] readaddr,
  output logic [7:0] readdata,
  input  logic [4:0] writeaddr,
  input  logic [7:0] writedata,
  input  logic       write_en,
  output logic       int_req,
  output logic [2:0] int_vec,
  input  logic       int_ack,
  input  logic       int_done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] enable_reg;
  logic [7:0] pending_reg, pending_next;
  logic [7:0] irq_prev_reg;
  logic       gctrl_reg;
  logic       int_req_next;
  logic [2:0] int_vec_next;
  logic       ack_clear;

  logic [7:0] irq_edge;
  logic [7:0] w1c_mask;
  logic [7:0] ack_mask;
  logic [7:0] eligible;
  logic [2:0] lowest_idx;
  logic [4:0] wr_off, rd_off;
  logic       wr_hit, rd_hit;
  logic [7:0] rd_value;

  // Offsets wrap in 5 bits, so anything below BASE_ADDR lands far outside 0..3.
  assign wr_off = writeaddr - BASE_ADDR;
  assign rd_off = readaddr - BASE_ADDR;
  assign wr_hit = write_en && (wr_off < 5'd4);
  assign rd_hit = (rd_off < 5'd4);

  assign irq_edge = irq_in & ~irq_prev_reg;
  assign w1c_mask = (wr_hit && wr_off[1:0] == 2'd1) ? writedata : 8'd0;
  assign ack_mask = ack_clear ? (8'd1 << int_vec) : 8'd0;
  assign eligible = pending_reg & enable_reg & {8{gctrl_reg}};

  // A new edge always wins over any clear of the same bit.
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_pending
      assign pending_next[gi] = irq_edge[gi] |
                                (pending_reg[gi] & ~w1c_mask[gi] & ~ack_mask[gi]);
    end
  endgenerate

  always_comb begin
    lowest_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (eligible[i]) lowest_idx = 3'(i);
    end
  end

  always_comb begin
    state_next   = state_reg;
    int_req_next = int_req;
    int_vec_next = int_vec;
    ack_clear    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (eligible != 8'd0) begin
          int_vec_next = lowest_idx;
          int_req_next = 1'b1;
          state_next   = REQ;
        end
      end
      REQ: begin
        if (int_ack) begin
          ack_clear    = 1'b1;
          int_req_next = 1'b0;
          state_next   = SERVICE;
        end else if (!eligible[int_vec]) begin
          int_req_next = 1'b0;
          state_next   = IDLE;
        end
      end
      SERVICE: begin
        if (int_done) state_next = IDLE;
      end
      default: begin
        int_req_next = 1'b0;
        state_next   = IDLE;
      end
    endcase
  end

  always_comb begin
    rd_value = 8'd0;
    case (rd_off[1:0])
      2'd0: rd_value = enable_reg;
      2'd1: rd_value = pending_reg;
      2'd2: rd_value = {int_req, (state_reg == SERVICE), 3'b000, int_vec};
      2'd3: rd_value = {7'd0, gctrl_reg};
      default: rd_value = 8'd0;
    endcase
  end

  // All-ones history keeps lines already high at reset release from latching.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      enable_reg   <= 8'd0;
      pending_reg  <= 8'd0;
      irq_prev_reg <= 8'hFF;
      gctrl_reg    <= 1'b0;
      int_req      <= 1'b0;
      int_vec      <= 3'd0;
      readdata     <= 8'd0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      irq_prev_reg <= irq_in;
      int_req      <= int_req_next;
      int_vec      <= int_vec_next;
      readdata     <= rd_hit ? rd_value : 8'd0;
      if (wr_hit && wr_off[1:0] == 2'd0) enable_reg <= writedata;
      if (wr_hit && wr_off[1:0] == 2'd3) gctrl_reg <= writedata[0];
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl with hand-computed expectations.
module tb_intr_ctrl;

  localparam logic [4:0] A_EN   = 5'd4;
  localparam logic [4:0] A_PEND = 5'd5;
  localparam logic [4:0] A_STAT = 5'd6;
  localparam logic [4:0] A_GC   = 5'd7;

  logic       clk;
  logic       reset;
  logic [7:0] irq_in;
  logic [4:0] readaddr;
  logic [7:0] readdata;
  logic [4:0] writeaddr;
  logic [7:0] writedata;
  logic       write_en;
  logic       int_req;
  logic [2:0] int_vec;
  logic       int_ack;
  logic       int_done;

  int n_checks;
  int n_errors;
  logic [7:0] rv;

  intr_ctrl #(.BASE_ADDR(5'd4)) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in),
    .readaddr(readaddr), .readdata(readdata),
    .writeaddr(writeaddr), .writedata(writedata), .write_en(write_en),
    .int_req(int_req), .int_vec(int_vec),
    .int_ack(int_ack), .int_done(int_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end else begin
      $display("ok   %s: %02h", tag, got);
    end
  endtask

  task automatic do_reset(input logic [7:0] irq);
    reset = 1'b1; irq_in = irq; readaddr = 5'd0; writeaddr = 5'd0;
    writedata = 8'd0; write_en = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    writeaddr = a; writedata = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] a, output logic [7:0] d);
    readaddr = a;
    tick();
    d = readdata;
    readaddr = 5'd0;
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1; tick(); int_ack = 1'b0;
  endtask

  task automatic pulse_done();
    int_done = 1'b1; tick(); int_done = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // Lines held high through reset release must not latch.
    do_reset(8'h0F);
    check_val("rst_int_req", {7'd0, int_req}, 8'h00);
    check_val("rst_int_vec", {5'd0, int_vec}, 8'h00);
    check_val("rst_readdata", readdata, 8'h00);
    rd(A_EN, rv);   check_val("rst_enable", rv, 8'h00);
    wr(A_EN, 8'hFF);
    wr(A_GC, 8'h01);
    tick(); tick();
    rd(A_PEND, rv); check_val("held_high_pending", rv, 8'h00);
    check_val("held_high_req", {7'd0, int_req}, 8'h00);

    // Single line, full handshake.
    do_reset(8'h00);
    wr(A_EN, 8'h01);
    wr(A_GC, 8'h01);
    irq_in = 8'h01; readaddr = A_PEND;
    tick();
    check_val("t2_req_after_k", {7'd0, int_req}, 8'h00);
    tick();
    check_val("t2_pending_after_k", readdata, 8'h01);
    check_val("t2_req_after_k1", {7'd0, int_req}, 8'h01);
    check_val("t2_vec", {5'd0, int_vec}, 8'h00);
    readaddr = 5'd0;
    pulse_ack();
    check_val("t2_req_after_ack", {7'd0, int_req}, 8'h00);
    rd(A_PEND, rv); check_val("t2_pending_cleared", rv, 8'h00);
    rd(A_STAT, rv); check_val("t2_status_service", rv, 8'h40);
    pulse_done();
    rd(A_STAT, rv); check_val("t2_status_idle", rv, 8'h00);

    // Simultaneous rises: lowest index first, then the other.
    do_reset(8'h00);
    wr(A_EN, 8'hFF);
    wr(A_GC, 8'h01);
    irq_in = 8'h24;
    tick(); tick();
    check_val("t3_first_req", {7'd0, int_req}, 8'h01);
    check_val("t3_first_vec", {5'd0, int_vec}, 8'h02);
    pulse_ack();
    pulse_done();
    tick();
    check_val("t3_second_req", {7'd0, int_req}, 8'h01);
    check_val("t3_second_vec", {5'd0, int_vec}, 8'h05);

    // Withdraw by W1C while requesting.
    do_reset(8'h00);
    wr(A_EN, 8'hFF);
    wr(A_GC, 8'h01);
    irq_in = 8'h08;
    tick(); tick();
    check_val("t4_req_vec3", {4'd0, int_req, int_vec}, 8'h0B);
    wr(A_PEND, 8'h08);
    tick();
    check_val("t4_withdrawn", {7'd0, int_req}, 8'h00);
    rd(A_STAT, rv); check_val("t4_status_idle_bits", rv & 8'hC0, 8'h00);
    tick(); tick();
    check_val("t4_stays_low", {7'd0, int_req}, 8'h00);

    // Ack coinciding with a new edge on the same line.
    do_reset(8'h00);
    wr(A_EN, 8'hFF);
    wr(A_GC, 8'h01);
    irq_in = 8'h02;
    tick(); tick();
    check_val("t5_req_vec1", {4'd0, int_req, int_vec}, 8'h09);
    irq_in = 8'h00;
    tick();
    irq_in = 8'h02;
    pulse_ack();
    check_val("t5_req_after_ack", {7'd0, int_req}, 8'h00);
    rd(A_PEND, rv); check_val("t5_pending_kept", rv, 8'h02);
    tick();
    check_val("t5_no_nesting", {7'd0, int_req}, 8'h00);
    pulse_done();
    tick();
    check_val("t5_rerequest", {4'd0, int_req, int_vec}, 8'h09);

    // Register readback and out-of-window behaviour.
    wr(A_GC, 8'hFF);
    rd(A_GC, rv);   check_val("gctrl_readback", rv, 8'h01);
    rd(5'd0, rv);   check_val("read_outside", rv, 8'h00);
    wr(5'd20, 8'h55);
    rd(A_EN, rv);   check_val("write_outside_ignored", rv, 8'hFF);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
